// File: rtl/proc_ctrl_fsm_pkg.sv
// Shared definitions for the processor control sequencer: opcodes, bus select
// codes, ALU operations, branch conditions and the sequencer state type.
package proc_pkg;

  localparam logic [2:0] OP_MV  = 3'd0;
  localparam logic [2:0] OP_MVT = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_LD  = 3'd4;
  localparam logic [2:0] OP_ST  = 3'd5;
  localparam logic [2:0] OP_AND = 3'd6;
  localparam logic [2:0] OP_B   = 3'd7;

  localparam logic [3:0] SEL_IMM = 4'd8;
  localparam logic [3:0] SEL_DIN = 4'd9;
  localparam logic [3:0] SEL_G   = 4'd10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

  localparam logic [2:0] COND_AL = 3'd0;
  localparam logic [2:0] COND_EQ = 3'd1;
  localparam logic [2:0] COND_NE = 3'd2;

  typedef enum logic [2:0] {
    FETCH_ADDR,
    FETCH_WAIT,
    FETCH_IR,
    EX1,
    EX2,
    EX3
  } state_e;

  function automatic logic [1:0] alu_of(input logic [2:0] op);
    case (op)
      OP_SUB:  alu_of = ALU_SUB;
      OP_AND:  alu_of = ALU_AND;
      default: alu_of = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/proc_ctrl_fsm_if.sv
// Control/status bundle between the sequencer (master) and the datapath (slave).
interface proc_ctrl_fsm_if #(parameter int DATA_W = 16);
  logic              run;
  logic [DATA_W-1:0] ir;
  logic              z_flag;
  logic [3:0]        sel;
  logic [7:0]        r_in;
  logic              a_in;
  logic              g_in;
  logic              ir_in;
  logic              addr_in;
  logic              dout_in;
  logic              w_d;
  logic              pc_incr;
  logic [1:0]        alu_op;
  logic              done;

  modport master (
    input  run, ir, z_flag,
    output sel, r_in, a_in, g_in, ir_in, addr_in, dout_in, w_d, pc_incr, alu_op, done
  );

  modport slave (
    output run, ir, z_flag,
    input  sel, r_in, a_in, g_in, ir_in, addr_in, dout_in, w_d, pc_incr, alu_op, done
  );
endinterface

// File: rtl/proc_ctrl_fsm_ir_decode.sv
// Combinational field split of the registered instruction word.
module proc_ir_decode
  import proc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] ir_i,
  output logic [2:0]        opcode_o,
  output logic              imm_o,
  output logic [2:0]        x_o,
  output logic [7:0]        x_oh_o,
  output logic [2:0]        y_o,
  output logic [2:0]        cond_o
);
  logic unused_bits;

  assign opcode_o    = ir_i[15:13];
  assign imm_o       = ir_i[12];
  assign x_o         = ir_i[11:9];
  assign x_oh_o      = 8'(1) << ir_i[11:9];
  assign y_o         = ir_i[2:0];
  // Branches reuse the X field as their condition code.
  assign cond_o      = ir_i[11:9];
  assign unused_bits = ^ir_i[8:3];
endmodule

// File: rtl/proc_ctrl_fsm.sv
// Multi-cycle control sequencer: fetch, decode and drive datapath controls,
// one instruction every 4 to 6 cycles.
module proc_ctrl_fsm
  import proc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PC_IDX = 7
) (
  input logic            clk,
  input logic            reset,
  proc_ctrl_fsm_if.master bus
);
  state_e      state_q, state_d;
  logic [2:0]  opcode, x, y, cond;
  logic [7:0]  x_oh;
  logic        imm;
  logic [3:0]  op_sel;
  logic        taken;

  proc_ir_decode #(.DATA_W(DATA_W)) u_dec (
    .ir_i     (bus.ir),
    .opcode_o (opcode),
    .imm_o    (imm),
    .x_o      (x),
    .x_oh_o   (x_oh),
    .y_o      (y),
    .cond_o   (cond)
  );

  assign op_sel = imm ? SEL_IMM : {1'b0, y};

  always_comb begin
    case (cond)
      COND_AL: taken = 1'b1;
      COND_EQ: taken = bus.z_flag;
      COND_NE: taken = ~bus.z_flag;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH_ADDR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    bus.sel     = '0;
    bus.r_in    = '0;
    bus.a_in    = 1'b0;
    bus.g_in    = 1'b0;
    bus.ir_in   = 1'b0;
    bus.addr_in = 1'b0;
    bus.dout_in = 1'b0;
    bus.w_d     = 1'b0;
    bus.pc_incr = 1'b0;
    bus.alu_op  = ALU_ADD;
    bus.done    = 1'b0;
    // Reset masks every strobe so an aborted instruction leaves no partial write.
    if (!reset) begin
      case (state_q)
        FETCH_ADDR: if (bus.run) begin
          bus.sel     = 4'(PC_IDX);
          bus.addr_in = 1'b1;
          bus.pc_incr = 1'b1;
          state_d     = FETCH_WAIT;
        end
        FETCH_WAIT: state_d = FETCH_IR;
        FETCH_IR: begin
          bus.sel   = SEL_DIN;
          bus.ir_in = 1'b1;
          state_d   = EX1;
        end
        EX1: begin
          state_d = EX2;
          case (opcode)
            OP_MV:  begin bus.sel = op_sel;  bus.r_in = x_oh; bus.done = 1'b1; end
            OP_MVT: begin bus.sel = SEL_IMM; bus.r_in = x_oh; bus.done = 1'b1; end
            OP_ADD, OP_SUB, OP_AND: begin bus.sel = {1'b0, x}; bus.a_in = 1'b1; end
            OP_LD, OP_ST:           begin bus.sel = {1'b0, y}; bus.addr_in = 1'b1; end
            default: begin
              if (taken) begin
                bus.sel  = 4'(PC_IDX);
                bus.a_in = 1'b1;
              end else begin
                bus.done = 1'b1;
              end
            end
          endcase
          if (bus.done) state_d = FETCH_ADDR;
        end
        EX2: begin
          state_d = EX3;
          case (opcode)
            OP_ADD, OP_SUB, OP_AND: begin
              bus.sel    = op_sel;
              bus.g_in   = 1'b1;
              bus.alu_op = alu_of(opcode);
            end
            OP_LD: ;
            OP_ST: begin bus.sel = {1'b0, x}; bus.dout_in = 1'b1; end
            OP_B:  begin bus.sel = SEL_IMM; bus.g_in = 1'b1; bus.alu_op = ALU_ADD; end
            default: state_d = FETCH_ADDR;
          endcase
        end
        EX3: begin
          state_d  = FETCH_ADDR;
          bus.done = 1'b1;
          case (opcode)
            OP_ADD, OP_SUB, OP_AND: begin bus.sel = SEL_G;   bus.r_in = x_oh; end
            OP_LD:                  begin bus.sel = SEL_DIN; bus.r_in = x_oh; end
            OP_ST:                  bus.w_d = 1'b1;
            OP_B:                   begin bus.sel = SEL_G; bus.r_in = 8'(1) << PC_IDX; end
            default:                bus.done = 1'b0;
          endcase
        end
        default: state_d = FETCH_ADDR;
      endcase
    end
  end
endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Randomized self-checking bench for proc_ctrl_fsm against a per-instruction
// cycle-list reference model.
module tb_proc_ctrl_fsm;
  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] r_in;
    logic       a_in, g_in, ir_in, addr_in, dout_in, w_d, pc_incr;
    logic [1:0] alu_op;
    logic       done;
  } outs_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  outs_t exp_q[$];

  proc_ctrl_fsm_if #(.DATA_W(16)) bus ();

  proc_ctrl_fsm #(.DATA_W(16), .PC_IDX(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic outs_t actual();
    return {bus.sel, bus.r_in, bus.a_in, bus.g_in, bus.ir_in, bus.addr_in,
            bus.dout_in, bus.w_d, bus.pc_incr, bus.alu_op, bus.done};
  endfunction

  function automatic outs_t mk(int sel, int rin, bit a, bit g, bit irl, bit ad,
                               bit dt, bit w, bit pc, int alu, bit dn);
    outs_t e;
    e.sel = 4'(sel); e.r_in = 8'(rin); e.a_in = a; e.g_in = g; e.ir_in = irl;
    e.addr_in = ad; e.dout_in = dt; e.w_d = w; e.pc_incr = pc;
    e.alu_op = 2'(alu); e.done = dn;
    return e;
  endfunction

  // Expected output per cycle of one instruction, starting in the fetch-address cycle.
  function automatic void build(input logic [15:0] ir, input bit z);
    int op   = int'(ir[15:13]);
    int x    = int'(ir[11:9]);
    int y    = int'(ir[2:0]);
    int opnd = ir[12] ? 8 : y;
    int rx   = 1 << x;
    bit tk;
    exp_q.delete();
    exp_q.push_back(mk(7, 0, 0,0,0,1,0,0,1, 0, 0));
    exp_q.push_back(mk(0, 0, 0,0,0,0,0,0,0, 0, 0));
    exp_q.push_back(mk(9, 0, 0,0,1,0,0,0,0, 0, 0));
    case (op)
      0: exp_q.push_back(mk(opnd, rx, 0,0,0,0,0,0,0, 0, 1));
      1: exp_q.push_back(mk(8,    rx, 0,0,0,0,0,0,0, 0, 1));
      2, 3, 6: begin
        exp_q.push_back(mk(x,    0,  1,0,0,0,0,0,0, 0, 0));
        exp_q.push_back(mk(opnd, 0,  0,1,0,0,0,0,0, (op == 2) ? 0 : (op == 3) ? 1 : 2, 0));
        exp_q.push_back(mk(10,   rx, 0,0,0,0,0,0,0, 0, 1));
      end
      4: begin
        exp_q.push_back(mk(y, 0,  0,0,0,1,0,0,0, 0, 0));
        exp_q.push_back(mk(0, 0,  0,0,0,0,0,0,0, 0, 0));
        exp_q.push_back(mk(9, rx, 0,0,0,0,0,0,0, 0, 1));
      end
      5: begin
        exp_q.push_back(mk(y, 0, 0,0,0,1,0,0,0, 0, 0));
        exp_q.push_back(mk(x, 0, 0,0,0,0,1,0,0, 0, 0));
        exp_q.push_back(mk(0, 0, 0,0,0,0,0,1,0, 0, 1));
      end
      default: begin
        tk = (x == 0) || (x == 1 && z) || (x == 2 && !z);
        if (tk) begin
          exp_q.push_back(mk(7,  0,    1,0,0,0,0,0,0, 0, 0));
          exp_q.push_back(mk(8,  0,    0,1,0,0,0,0,0, 0, 0));
          exp_q.push_back(mk(10, 8'h80, 0,0,0,0,0,0,0, 0, 1));
        end else begin
          exp_q.push_back(mk(0, 0, 0,0,0,0,0,0,0, 0, 1));
        end
      end
    endcase
  endfunction

  // Runs one instruction from FETCH_ADDR; z is presented only in EX1, noise elsewhere.
  task automatic run_instr(input string name, input logic [15:0] ir, input bit z);
    outs_t act;
    int w_exp = 0, w_act = 0, d_act = 0;
    build(ir, z);
    foreach (exp_q[i]) if (exp_q[i].w_d) w_exp++;
    foreach (exp_q[i]) begin
      bus.run    = 1'b1;
      bus.ir     = ir;
      bus.z_flag = (i == 3) ? z : 1'($urandom_range(0, 1));
      @(negedge clk);
      act = actual();
      n_cmp++;
      if (act !== exp_q[i]) begin
        n_err++;
        $display("FAIL %s ir=%h z=%0d cycle %0d: got %h, want %h", name, ir, z, i, act, exp_q[i]);
      end
      if (act.w_d) w_act++;
      if (act.done) d_act++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (w_act !== w_exp || d_act !== 1) begin
      n_err++;
      $display("FAIL %s_pulses ir=%h: w_d %0d done %0d, want w_d %0d done 1", name, ir, w_act, d_act, w_exp);
    end
  endtask

  task automatic expect_idle(input string name, input int cycles);
    outs_t act;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      act = actual();
      n_cmp++;
      if (act !== '0) begin
        n_err++;
        $display("FAIL %s cycle %0d: got %h, want 0", name, i, act);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.run = 1'b1; bus.ir = 16'h5403; bus.z_flag = 1'b0;
    #1;
    expect_idle("reset_outputs", 2);
    reset = 1'b0;
    run_instr("post_reset_mvt", 16'h3205, 1'b0);
  endtask

  task automatic test_directed();
    run_instr("add", 16'h5403, 1'b0);
    run_instr("st",  16'hA204, 1'b1);
    run_instr("beq_nt", 16'hE3FE, 1'b0);
    run_instr("beq_t",  16'hE3FE, 1'b1);
    run_instr("ld",  16'h8E05, 1'b0);
    run_instr("mv_r7", 16'h0E01, 1'b0);
    run_instr("b_never", 16'hE7FF, 1'b1);
  endtask

  task automatic test_run_hold();
    bus.run = 1'b0;
    expect_idle("run_low_hold", 4);
    run_instr("after_hold", 16'h7A03, 1'b0);
  endtask

  task automatic test_reset_mid();
    outs_t act;
    build(16'h5403, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bus.run = 1'b1; bus.ir = 16'h5403; bus.z_flag = 1'b0;
      @(negedge clk);
      act = actual();
      n_cmp++;
      if (act !== exp_q[i]) begin
        n_err++;
        $display("FAIL abort_prefix cycle %0d: got %h, want %h", i, act, exp_q[i]);
      end
      @(posedge clk); #1;
    end
    reset = 1'b1;
    expect_idle("reset_in_ex2", 1);
    reset = 1'b0; bus.run = 1'b0;
    expect_idle("hold_after_abort", 3);
    run_instr("resume_after_abort", 16'h5403, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 80; n++)
      run_instr("random", 16'($urandom), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    test_reset();
    test_directed();
    test_run_hold();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
